// File: rtl/ctl_round.sv
// ctl_round: Duck Hunt game flow (rounds, ammo, BCD score, pass/fail).
// Define CTL_ROUND_PERFECT_BONUS_EN to award BONUS_POINTS on a perfect round.
module ctl_round #(
   parameter int DUCKS_PER_ROUND = 10,
   parameter int AMMO_PER_DUCK   = 3,
   parameter int PASS_HITS       = 6,
   parameter int FLY_FRAMES      = 300,
   parameter int FALL_FRAMES     = 60,
   parameter int SCORE_DIGITS    = 2,
   parameter int BONUS_POINTS    = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        new_frame,
   input  logic                        start,
   input  logic                        shot_fired,
   input  logic                        hit,
   output logic                        duck_launch,
   output logic                        duck_active,
   output logic                        duck_falling,
   output logic [3:0]                  ammo,
   output logic [4*SCORE_DIGITS-1:0]   score,
   output logic [7:0]                  round_num,
   output logic [DUCKS_PER_ROUND-1:0]  hit_flags,
   output logic                        game_over
);

   localparam int SW    = 4 * SCORE_DIGITS;
   localparam int DW    = DUCKS_PER_ROUND;
   localparam int IW    = $clog2(DUCKS_PER_ROUND + 1);
   localparam int CMAX0 = (FLY_FRAMES > FALL_FRAMES) ? FLY_FRAMES : FALL_FRAMES;
   localparam int CMAX  = (CMAX0 > BONUS_POINTS) ? CMAX0 : BONUS_POINTS;
   localparam int CW    = $clog2(CMAX + 1);

   localparam logic [CW-1:0] FLY_LAST  = CW'(FLY_FRAMES - 1);
   localparam logic [CW-1:0] FALL_LAST = CW'(FALL_FRAMES - 1);
   localparam logic [3:0]    AMMO_LD   = 4'(AMMO_PER_DUCK);
   localparam logic [IW-1:0] IDX_END   = IW'(DUCKS_PER_ROUND);
   localparam logic [SW-1:0] ALL9      = {SCORE_DIGITS{4'h9}};
`ifdef CTL_ROUND_PERFECT_BONUS_EN
   localparam logic [CW-1:0] BONUS_LAST = CW'(BONUS_POINTS - 1);
`endif

   typedef enum logic [3:0] {
      IDLE,
      LAUNCH,
      FLYING,
      FALLING,
      ESCAPE,
      NEXT,
      ROUND_END,
`ifdef CTL_ROUND_PERFECT_BONUS_EN
      BONUS,
`endif
      GAME_OVER
   } state_t;

   state_t          state, state_d;
   logic [IW-1:0]   idx, idx_d;
   logic [CW-1:0]   fcnt, fcnt_d;
   logic [3:0]      ammo_d;
   logic [SW-1:0]   score_d;
   logic [7:0]      round_d;
   logic [DW-1:0]   flags_d;
   logic            new_round;
   logic            shot_ok;

   // Ripple-carry BCD increment that sticks at all nines.
   function automatic logic [SW-1:0] score_inc(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      logic          c;
      r = s;
      c = 1'b1;
      if (s != ALL9) begin
         for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (c) begin
               if (r[4*i +: 4] == 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] rnd_inc(input logic [7:0] r);
      if (r == 8'h99)
         return r;
      if (r[3:0] == 4'd9)
         return {r[7:4] + 4'd1, 4'd0};
      return {r[7:4], r[3:0] + 4'd1};
   endfunction

   assign shot_ok = shot_fired && (ammo != 4'd0);

   always_comb begin
      state_d   = state;
      idx_d     = idx;
      fcnt_d    = fcnt;
      ammo_d    = ammo;
      score_d   = score;
      round_d   = round_num;
      flags_d   = hit_flags;
      new_round = 1'b0;
      unique case (state)
         IDLE, GAME_OVER: begin
            if (start) begin
               score_d = '0;
               flags_d = '0;
               idx_d   = '0;
               round_d = 8'h01;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            ammo_d  = AMMO_LD;
            fcnt_d  = '0;
            state_d = FLYING;
         end
         FLYING: begin
            if (shot_ok)
               ammo_d = ammo - 4'd1;
            // A hit wins over running dry or timing out in the same cycle.
            if (shot_ok && hit) begin
               flags_d = hit_flags | (DW'(1) << idx);
               score_d = score_inc(score);
               fcnt_d  = '0;
               state_d = FALLING;
            end else if (ammo == 4'd0 || (new_frame && fcnt == FLY_LAST)) begin
               fcnt_d  = '0;
               state_d = ESCAPE;
            end else if (new_frame) begin
               fcnt_d = fcnt + CW'(1);
            end
         end
         FALLING, ESCAPE: begin
            if (new_frame) begin
               if (fcnt == FALL_LAST)
                  state_d = NEXT;
               else
                  fcnt_d = fcnt + CW'(1);
            end
         end
         NEXT: begin
            idx_d   = idx + IW'(1);
            state_d = (idx_d == IDX_END) ? ROUND_END : LAUNCH;
         end
         ROUND_END: begin
            if ($countones(hit_flags) < PASS_HITS) begin
               state_d = GAME_OVER;
`ifdef CTL_ROUND_PERFECT_BONUS_EN
            end else if (&hit_flags && BONUS_POINTS > 0) begin
               fcnt_d  = '0;
               state_d = BONUS;
`endif
            end else begin
               new_round = 1'b1;
            end
         end
`ifdef CTL_ROUND_PERFECT_BONUS_EN
         BONUS: begin
            score_d = score_inc(score);
            if (fcnt == BONUS_LAST)
               new_round = 1'b1;
            else
               fcnt_d = fcnt + CW'(1);
         end
`endif
         default: state_d = IDLE;
      endcase
      if (new_round) begin
         round_d = rnd_inc(round_num);
         flags_d = '0;
         idx_d   = '0;
         state_d = LAUNCH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         fcnt         <= '0;
         ammo         <= '0;
         score        <= '0;
         round_num    <= '0;
         hit_flags    <= '0;
         duck_launch  <= 1'b0;
         duck_active  <= 1'b0;
         duck_falling <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_d;
         idx          <= idx_d;
         fcnt         <= fcnt_d;
         ammo         <= ammo_d;
         score        <= score_d;
         round_num    <= round_d;
         hit_flags    <= flags_d;
         duck_launch  <= (state == LAUNCH);
         duck_active  <= (state_d == FLYING);
         duck_falling <= (state_d == FALLING);
         game_over    <= (state_d == GAME_OVER);
      end
   end

endmodule

// File: tb/tb_ctl_round.sv
// tb_ctl_round: randomized duck-by-duck play of ctl_round against a
// game-level model (integer score/round, per-duck outcome plans).
module tb_ctl_round;

   localparam int ND    = 4;
   localparam int NA    = 3;
   localparam int NP    = 2;
   localparam int NFLY  = 8;
   localparam int NFALL = 3;
   localparam int NDIG  = 2;
   localparam int NB    = 5;
`ifdef CTL_ROUND_PERFECT_BONUS_EN
   localparam bit BON = 1'b1;
`else
   localparam bit BON = 1'b0;
`endif

   logic              clk, rst, new_frame, start, shot_fired, hit;
   logic              duck_launch, duck_active, duck_falling, game_over;
   logic [3:0]        ammo;
   logic [4*NDIG-1:0] score;
   logic [7:0]        round_num;
   logic [ND-1:0]     hit_flags;

   int            n_chk, n_pass;
   int            m_score, m_round, m_ammo, m_hits;
   logic [ND-1:0] m_flags;

   ctl_round #(
      .DUCKS_PER_ROUND(ND),
      .AMMO_PER_DUCK  (NA),
      .PASS_HITS      (NP),
      .FLY_FRAMES     (NFLY),
      .FALL_FRAMES    (NFALL),
      .SCORE_DIGITS   (NDIG),
      .BONUS_POINTS   (NB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .new_frame   (new_frame),
      .start       (start),
      .shot_fired  (shot_fired),
      .hit         (hit),
      .duck_launch (duck_launch),
      .duck_active (duck_active),
      .duck_falling(duck_falling),
      .ammo        (ammo),
      .score       (score),
      .round_num   (round_num),
      .hit_flags   (hit_flags),
      .game_over   (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int sat99(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input logic sf, input logic h, input logic nf,
                       input logic st);
      shot_fired = sf;
      hit        = h;
      new_frame  = nf;
      start      = st;
      @(posedge clk);
      #1;
      shot_fired = 1'b0;
      hit        = 1'b0;
      new_frame  = 1'b0;
      start      = 1'b0;
   endtask

   task automatic wait_launch(input int exp_lat, input string tag);
      int n;
      n = 0;
      do begin
         step(rb(), rb(), rb(), 1'b0);
         n++;
      end while (!duck_launch && n < 20);
      chk(tag, n, exp_lat);
      m_ammo = NA;
      chk("launch_active", duck_active, 1);
      chk("launch_ammo", ammo, m_ammo);
      chk("launch_score", score, to_bcd(m_score));
      chk("launch_round", round_num, to_bcd(m_round));
      chk("launch_flags", hit_flags, m_flags);
   endtask

   task automatic begin_game();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      m_score = 0;
      m_round = 1;
      m_flags = '0;
      chk("start_score", score, 0);
      chk("start_round", round_num, 8'h01);
      chk("start_flags", hit_flags, 0);
      chk("start_go", game_over, 0);
      chk("start_no_launch", duck_launch, 0);
      wait_launch(1, "start_lat");
   endtask

   // kind 0: hit after some misses, 1: run out of ammo, 2: fly away
   task automatic play_duck(input int idx, input int kind);
      int misses;
      int fr;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("launch_width", duck_launch, 0);
      if (kind == 0) begin
         misses = $urandom_range(0, NA - 1);
         fr = 0;
         for (int i = 0; i < misses; i++) begin
            if (rb() && fr < NFLY - 2) begin
               step(1'b0, 1'b0, 1'b1, 1'b0);
               fr++;
            end
            step(1'b1, 1'b0, 1'b0, 1'b0);
            m_ammo--;
            chk("miss_ammo", ammo, m_ammo);
            chk("miss_active", duck_active, 1);
         end
         step(1'b0, 1'b1, 1'b0, 1'b1);
         chk("lone_hit_active", duck_active, 1);
         chk("lone_hit_score", score, to_bcd(m_score));
         step(1'b1, 1'b1, 1'b0, 1'b0);
         m_ammo--;
         m_score = sat99(m_score + 1);
         m_flags[idx] = 1'b1;
         m_hits++;
         chk("hit_falling", duck_falling, 1);
         chk("hit_active", duck_active, 0);
         chk("hit_score", score, to_bcd(m_score));
         chk("hit_flags", hit_flags, m_flags);
         chk("hit_ammo", ammo, m_ammo);
      end else if (kind == 1) begin
         for (int i = 0; i < NA; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            m_ammo--;
            chk("dry_ammo", ammo, m_ammo);
         end
         chk("dry_still_flying", duck_active, 1);
         step(1'b1, 1'b0, 1'b0, 1'b0);
         chk("dry_extra_ammo", ammo, 0);
         chk("dry_escape", duck_active, 0);
         chk("dry_not_falling", duck_falling, 0);
      end else begin
         for (int f = 0; f < NFLY; f++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("timeout_active", duck_active, (f < NFLY - 1));
         end
         chk("timeout_flags", hit_flags, m_flags);
         chk("timeout_ammo", ammo, NA);
      end
      for (int f = 0; f < NFALL; f++) begin
         repeat ($urandom_range(0, 2)) begin
            step(rb(), rb(), 1'b0, rb());
            chk("fall_score", score, to_bcd(m_score));
            chk("fall_ammo", ammo, m_ammo);
         end
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("fall_state", duck_falling, (kind == 0 && f < NFALL - 1));
      end
   endtask

   task automatic play_round(input int kinds[ND], output bit over);
      int lat;
      m_flags = '0;
      m_hits  = 0;
      for (int i = 0; i < ND; i++) begin
         play_duck(i, kinds[i]);
         if (i < ND - 1)
            wait_launch(2, "launch_gap");
      end
      if (m_hits < NP) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("round_end_go", game_over, 0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("game_over", game_over, 1);
         chk("over_score", score, to_bcd(m_score));
         chk("over_flags", hit_flags, m_flags);
         chk("over_active", duck_active, 0);
         over = 1'b1;
      end else begin
         lat = 3;
         if (BON && m_hits == ND) begin
            lat += NB;
            m_score = sat99(m_score + NB);
         end
         m_round = sat99(m_round + 1);
         m_flags = '0;
         wait_launch(lat, "launch_round");
         over = 1'b0;
      end
   endtask

   task automatic rand_plan(output int kinds[ND]);
      int h;
      h = 0;
      for (int i = 0; i < ND; i++) begin
         kinds[i] = $urandom_range(0, 2);
         if (kinds[i] == 0) h++;
      end
      for (int i = 0; i < ND && h < NP; i++) begin
         if (kinds[i] != 0) begin
            kinds[i] = 0;
            h++;
         end
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_launch"}, duck_launch, 0);
      chk({tag, "_active"}, duck_active, 0);
      chk({tag, "_falling"}, duck_falling, 0);
      chk({tag, "_ammo"}, ammo, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_round"}, round_num, 0);
      chk({tag, "_flags"}, hit_flags, 0);
      chk({tag, "_go"}, game_over, 0);
   endtask

   initial begin
      int  plan[ND];
      bit  over;
      int  n;
      n_chk = 0;
      n_pass = 0;
      rst = 1'b0;
      new_frame = 1'b0;
      start = 1'b0;
      shot_fired = 1'b0;
      hit = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      rst = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("idle_ignore_launch", duck_launch, 0);
      chk("idle_ignore_score", score, 0);

      begin_game();
      plan = '{0, 1, 2, 0};
      play_round(plan, over);
      chk("round1_over", over, 0);
      plan = '{0, 0, 0, 0};
      play_round(plan, over);
      chk("perfect_over", over, 0);
      n = 0;
      while (m_score < 99 && n < 60) begin
         rand_plan(plan);
         play_round(plan, over);
         n++;
      end
      chk("score_sat", score, 8'h99);
      plan = '{0, 0, 0, 0};
      play_round(plan, over);
      chk("sat_score", score, 8'h99);

      plan = '{1, 2, 0, 1};
      play_round(plan, over);
      chk("fail_over", over, 1);
      begin_game();
      chk("restart_round", round_num, 8'h01);

      step(1'b1, 1'b0, 1'b0, 1'b0);
      m_ammo--;
      chk("pre_rst_ammo", ammo, m_ammo);
      #3 rst = 1'b1;
      #1;
      chk_reset("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      begin_game();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
